// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph constants (gfedcba, active-low) and hex lookup.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'h7F;

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    seg_t s;
    unique case (nibble)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      4'hF: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure table lookup
  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scanner with guard time, frame-synchronous capture,
// leading-zero blanking, per-digit blink and decimal points. All outputs registered.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned GUARD        = 1,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    lzb_en,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int unsigned TickW  = $clog2(SCAN_DIV);
  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TickW-1:0]  TickLast  = TickW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(NUM_DIGITS - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);

  logic [TickW-1:0]  tick;
  logic [IdxW-1:0]   idx;
  logic [BlinkW-1:0] blink_cnt;
  logic              blink_phase;
  logic              load_pending;

  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blink;
  logic                    sh_lzb;

  logic frame_end;
  logic capture;
  logic in_guard;

  assign frame_end = (tick == TickLast) && (idx == IdxLast);
  // The post-reset load starts the first frame without waiting a full scan.
  assign capture   = load_pending | frame_end;

  // A zero guard makes the guard window empty; kept structural to avoid constant compares.
  if (GUARD != 0) begin : g_guard
    localparam logic [TickW-1:0] GuardTick = TickW'(GUARD);
    assign in_guard = (tick < GuardTick);
  end else begin : g_no_guard
    assign in_guard = 1'b0;
  end

  // Slot timer and digit index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick <= '0;
      idx  <= '0;
    end else if (tick == TickLast) begin
      tick <= '0;
      idx  <= (idx == IdxLast) ? '0 : idx + 1'b1;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  // Shadow capture at frame boundaries so a frame never mixes old and new data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_value     <= '0;
      sh_dp        <= '0;
      sh_blink     <= '0;
      sh_lzb       <= 1'b0;
      load_pending <= 1'b1;
    end else if (capture) begin
      sh_value     <= value;
      sh_dp        <= dp;
      sh_blink     <= blink;
      sh_lzb       <= lzb_en;
      load_pending <= 1'b0;
    end
  end

  // Blink timebase counted in frames; the post-reset load is not a frame end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BlinkLast) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blink;
  logic                  cur_lz;
  logic                  upper_zero;
  logic [NUM_DIGITS-1:0] an_sel;
  logic                  blank_digit;
  logic [6:0]            glyph;

  // Select the current digit and work out whether it is a leading zero
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blink  = 1'b0;
    cur_lz     = 1'b0;
    upper_zero = 1'b1;
    an_sel     = '1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      upper_zero = upper_zero & (sh_value[4*k +: 4] == 4'h0);
      if (idx == IdxW'(k)) begin
        cur_nib   = sh_value[4*k +: 4];
        cur_dp    = sh_dp[k];
        cur_blink = sh_blink[k];
        cur_lz    = upper_zero && (k != 0);
        an_sel[k] = 1'b0;
      end
    end
    blank_digit = (cur_blink & blink_phase) | (sh_lzb & cur_lz);
  end

  seg7_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (glyph)
  );

  // Registered pin drive; guard cycles turn everything off to prevent ghosting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_n       <= SEG_BLANK;
      dp_n        <= 1'b1;
      an_n        <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= capture;
      if (in_guard) begin
        seg_n <= SEG_BLANK;
        dp_n  <= 1'b1;
        an_n  <= '1;
      end else begin
        seg_n <= blank_digit ? SEG_BLANK : glyph;
        dp_n  <= blank_digit | ~cur_dp;
        an_n  <= an_sel;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: two configurations checked every cycle against a frame-arithmetic model.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Configuration 0: 4 digits, 4-cycle slots, 1 guard, 2 frames per blink half-period
  logic [15:0] value0;
  logic [3:0]  dp0, blink0, an_n0;
  logic        lzb0, dp_n0, fs0;
  logic [6:0]  seg_n0;

  // Configuration 1: 1 digit, 3-cycle slots, no guard, 3 frames per blink half-period
  logic [3:0] value1;
  logic       dp1, blink1, lzb1, dp_n1, fs1;
  logic [0:0] an_n1;
  logic [6:0] seg_n1;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .GUARD(1), .BLINK_FRAMES(2)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .value(value0), .dp(dp0), .blink(blink0), .lzb_en(lzb0),
    .seg_n(seg_n0), .dp_n(dp_n0), .an_n(an_n0), .frame_start(fs0)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(1), .SCAN_DIV(3), .GUARD(0), .BLINK_FRAMES(3)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .value(value1), .dp(dp1), .blink(blink1), .lzb_en(lzb1),
    .seg_n(seg_n1), .dp_n(dp_n1), .an_n(an_n1), .frame_start(fs1)
  );

  int unsigned p_nd[2] = '{4, 1};
  int unsigned p_sd[2] = '{4, 3};
  int unsigned p_g[2]  = '{1, 0};
  int unsigned p_bf[2] = '{2, 3};

  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Bench-side inputs and model state
  logic [31:0] in_val[2];
  logic [7:0]  in_dp[2], in_bl[2];
  logic        in_lz[2];
  int unsigned n_m[2];
  logic [31:0] sh_val[2];
  logic [7:0]  sh_dp[2], sh_bl[2];
  logic        sh_lz[2];

  assign value0 = in_val[0][15:0];
  assign dp0    = in_dp[0][3:0];
  assign blink0 = in_bl[0][3:0];
  assign lzb0   = in_lz[0];
  assign value1 = in_val[1][3:0];
  assign dp1    = in_dp[1][0];
  assign blink1 = in_bl[1][0];
  assign lzb1   = in_lz[1];

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    logic       fs;
  } exp_t;

  exp_t q0[$], q1[$];
  int checks = 0;
  int failures = 0;

  // Expected pins for edge n since release: n selects frame n/F and position n%F
  function automatic exp_t model_out(int m);
    exp_t        r;
    int unsigned fl, p, d, t, f, nib;
    logic        phase, blank;
    fl    = p_nd[m] * p_sd[m];
    p     = n_m[m] % fl;
    d     = p / p_sd[m];
    t     = p % p_sd[m];
    f     = n_m[m] / fl;
    phase = ((f / p_bf[m]) % 2) == 1;
    nib   = (sh_val[m] >> (4 * d)) & 32'hF;
    blank = (sh_bl[m][d] && phase) || (sh_lz[m] && d > 0 && (sh_val[m] >> (4 * d)) == 0);
    r.fs  = (n_m[m] == 0) || (p == fl - 1);
    if (t < p_g[m]) begin
      r.seg = 7'h7F;
      r.dp  = 1'b1;
      r.an  = 8'hFF;
    end else begin
      r.seg = blank ? 7'h7F : glyph[nib];
      r.dp  = blank ? 1'b1 : ~sh_dp[m][d];
      r.an  = ~(8'h01 << d);
    end
    return r;
  endfunction

  task automatic step(int m);
    exp_t e;
    if (!rst_n) begin
      e         = '{seg: 7'h7F, dp: 1'b1, an: 8'hFF, fs: 1'b0};
      n_m[m]    = 0;
      sh_val[m] = '0;
      sh_dp[m]  = '0;
      sh_bl[m]  = '0;
      sh_lz[m]  = 1'b0;
    end else begin
      e = model_out(m);
      if (e.fs) begin
        sh_val[m] = in_val[m] & ((32'h1 << (4 * p_nd[m])) - 1);
        sh_dp[m]  = in_dp[m];
        sh_bl[m]  = in_bl[m];
        sh_lz[m]  = in_lz[m];
      end
      n_m[m]++;
    end
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic run(int k);
    repeat (k) begin
      step(0);
      step(1);
      @(negedge clk);
    end
  endtask

  // Advance until the next edge of configuration 0 lands on frame position p
  task automatic run_to(int unsigned p);
    while ((n_m[0] % 16) != p) run(1);
  endtask

  task automatic rand_inputs();
    for (int m = 0; m < 2; m++) begin
      in_val[m] = $urandom();
      in_dp[m]  = 8'($urandom());
      in_bl[m]  = 8'($urandom());
      in_lz[m]  = 1'($urandom());
    end
    // Bias toward leading zeros so blanking is exercised
    if ($urandom_range(0, 1) == 1) in_val[0] = in_val[0] >> (4 * $urandom_range(1, 4));
    if ($urandom_range(0, 2) == 0) in_val[1] = 32'h0;
  endtask

  // Monitor: every cycle each DUT presents pins; compare against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        checks++;
        if ({seg_n0, dp_n0, an_n0, fs0} !== {e.seg, e.dp, e.an[3:0], e.fs}) begin
          failures++;
          $display("FAIL cfg0_pins t=%0t got seg=%b dp=%b an=%b fs=%b want seg=%b dp=%b an=%b fs=%b",
                   $time, seg_n0, dp_n0, an_n0, fs0, e.seg, e.dp, e.an[3:0], e.fs);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checks++;
        if ({seg_n1, dp_n1, an_n1, fs1} !== {e.seg, e.dp, e.an[0], e.fs}) begin
          failures++;
          $display("FAIL cfg1_pins t=%0t got seg=%b dp=%b an=%b fs=%b want seg=%b dp=%b an=%b fs=%b",
                   $time, seg_n1, dp_n1, an_n1, fs1, e.seg, e.dp, e.an[0], e.fs);
        end
      end
    end
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      in_val[m] = '0; in_dp[m] = '0; in_bl[m] = '0; in_lz[m] = 1'b0;
      n_m[m] = 0; sh_val[m] = '0; sh_dp[m] = '0; sh_bl[m] = '0; sh_lz[m] = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);

    // Full hex glyphs, no blanking
    in_val[0] = 32'h12EF;
    in_val[1] = 32'hE;
    run(2);
    rst_n = 1'b1;
    run(32);

    // Leading-zero blanking
    in_val[0] = 32'h0040; in_lz[0] = 1'b1;
    in_val[1] = 32'h0;    in_lz[1] = 1'b1;
    run(32);

    // Mid-frame change must not tear
    in_val[0] = 32'h1111; in_lz[0] = 1'b0;
    run(20);
    run_to(6);
    in_val[0] = 32'h2222;
    run(32);

    // Blink and decimal point
    in_val[0] = 32'h0008; in_dp[0] = 8'h01; in_bl[0] = 8'h01;
    in_val[1] = 32'h8;    in_dp[1] = 8'h01; in_bl[1] = 8'h01; in_lz[1] = 1'b0;
    run(16 * 9);

    // One-cycle reset in the middle of digit 2's slot
    run_to(9);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    run(40);

    // Randomized inputs with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) rand_inputs();
      rst_n = ($urandom_range(0, 299) != 0);
      run(1);
    end
    rst_n = 1'b1;
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits sharing one segment bus. Next generation of the single-digit BCD-to-segment decoder.
- Adds:
  - full hex glyphs, including E and F
  - digit scanning with anti-ghost guard time
  - leading-zero blanking
  - per-digit blink and decimal points
  - tear-free frame-synchronous capture of the display value
- Sits between the lock/keypad datapath and the board I/O pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- SCAN_DIV, 1000, clk cycles each digit is selected (>= GUARD+2).
- GUARD, 1, cycles at the start of each digit slot with all anodes off (0..SCAN_DIV-2).
- BLINK_FRAMES, 250, full scan frames per blink half-period (>= 1).

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, synchronous active-low reset.
- value, in, 4*NUM_DIGITS, hex nibbles; digit k = value[4k+3:4k], digit 0 rightmost.
- dp, in, NUM_DIGITS, decimal point request per digit (1 = lit).
- blink, in, NUM_DIGITS, per-digit blink enable.
- lzb_en, in, 1, leading-zero blanking enable.
- seg_n, out, 7, segments {g,f,e,d,c,b,a}, active-low.
- dp_n, out, 1, decimal point, active-low.
- an_n, out, NUM_DIGITS, digit anodes, active-low, one-hot-low or all high.
- frame_start, out, 1, one-cycle pulse when shadow registers load.

Behaviour:
- Reset: one clock, synchronous active-low. While rst_n=0 at a clk edge:
  - seg_n=7'h7F, dp_n=1, an_n=all ones, frame_start=0.
  - tick=0, idx=0, blink_cnt=0, blink_phase=0, shadow regs=0, load_pending=1.
- Reset mid-scan returns to this state on the next edge. No partial digit persists.
- Counters:
  - tick counts 0..SCAN_DIV-1 and wraps.
  - On wrap, idx advances 0..NUM_DIGITS-1 and wraps to 0.
- Frame capture: at the first edge with rst_n=1, and on every edge where tick==SCAN_DIV-1 and idx==NUM_DIGITS-1:
  - value, dp, blink, lzb_en load into shadow registers; frame_start=1 for that cycle.
  - Inputs changing mid-frame have no visible effect until the next frame.
- Blink:
  - blink_cnt increments at each capture (excluding the post-reset capture).
  - On reaching BLINK_FRAMES-1 it clears and blink_phase toggles.
  - A digit with shadow blink=1 is blank (segments and dp off, anode still driven) when blink_phase=1.
- Leading-zero blanking (shadow lzb_en=1):
  - Digit k>0 is blank if all shadow nibbles k..NUM_DIGITS-1 are 0.
  - Digit 0 is never blanked by LZB (value 0 shows "0").
  - dp on a blanked digit is also off.
- Glyphs (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111
- Outputs are registered with one cycle of latency. On the edge after state (tick,idx) holds:
  - an_n[idx]=0 only if tick>=GUARD, otherwise all ones.
  - seg_n and dp_n hold the glyph of shadow digit idx after blink/LZB.
  - seg_n and dp_n are also forced to blank during guard cycles.
- Simultaneous events:
  - A capture edge also advances idx to 0.
  - The first slot of the new frame uses the newly loaded shadow data.
  - Blink phase toggle and capture on the same edge both take effect for the new frame.
- Width rules:
  - tick width $clog2(SCAN_DIV); idx width $clog2(NUM_DIGITS), minimum 1.
  - blink_cnt width $clog2(BLINK_FRAMES), minimum 1.
  - No out-of-range idx is ever reachable.

Decomposition:
- Package seg7_pkg holds:
  - the 16 glyph localparams and SEG_BLANK=7'h7F
  - typedef seg_t (logic [6:0]) and function hex_to_seg(nibble)
- Natural sub-module: seg7_hex_decode, a combinational nibble->seg_t using seg7_pkg. Instantiated once on the muxed digit.
- Scanning, capture, blink and LZB logic stay in seg7_scan_driver.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2 unless stated):
- Reset then value=16'h12EF, lzb_en=0:
  - first frame slots give an_n 1110/1101/1011/0111 for 3 cycles each after one all-ones guard cycle;
  - seg_n=0001110, 0000110, 0100100, 1111001 respectively.
- value=16'h0040, lzb_en=1: digits 3 and 2 show 1111111 with anode active; digit 1 shows 0011001; digit 0 shows 1000000.
- Change value from 16'h1111 to 16'h2222 mid-frame (idx=1): remaining slots of that frame still show 1111001; next frame shows 0100100; frame_start pulses once at the boundary.
- blink=4'b0001, dp=4'b0001, value=16'h0008:
  - digit 0 shows seg_n=0000000, dp_n=0 for frames 1-2;
  - seg_n=1111111, dp_n=1 for frames 3-4;
  - then repeats; other digits are unaffected.
- Assert rst_n=0 for one cycle mid-slot at idx=2:
  - next edge gives all outputs at reset values;
  - after release, scan restarts at idx=0 with shadow reloaded and frame_start=1.
- NUM_DIGITS=1, SCAN_DIV=3, GUARD=0: an_n stays 0 continuously after the first registered cycle; frame_start pulses every 3 cycles.
